// File: rtl/register_bank_ctrl_if.sv
// Host-side bus of the register bank: valid/ready writes, fixed-latency reads
// and the commit handshake that publishes staged control values.
interface register_bank_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_strb;
  logic                  wr_err;
  logic                  rd_valid;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_rsp_valid;
  logic [DATA_W-1:0]     rd_rsp_data;
  logic                  rd_err;
  logic                  commit;
  logic                  commit_done;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, commit,
    input  wr_ready, wr_err, rd_rsp_valid, rd_rsp_data, rd_err, commit_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, commit,
    output wr_ready, wr_err, rd_rsp_valid, rd_rsp_data, rd_err, commit_done
  );
endinterface

// File: rtl/register_bank_ctrl.sv
// Staged control register bank with atomic commit to live outputs, plus a
// sticky write-1-to-clear status register driving a registered interrupt.
module register_bank_ctrl #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 8,
  parameter int                ADDR_W    = $clog2(NUM_REGS + 1),
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       register_clk,
  input  logic                       register_rst,
  register_bank_ctrl_if.slave        bus,
  output logic [NUM_REGS*DATA_W-1:0] register,
  input  logic [DATA_W-1:0]          register_status,
  output logic                       irq
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_REGS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] stg_q  [NUM_REGS];
  logic [DATA_W-1:0] stg_d  [NUM_REGS];
  logic [DATA_W-1:0] live_q [NUM_REGS];
  logic [DATA_W-1:0] live_d [NUM_REGS];
  logic [DATA_W-1:0] sticky_q, sticky_d;
  logic [DATA_W-1:0] rd_rsp_data_q, rd_rsp_data_d;
  logic [DATA_W-1:0] clr;
  logic              irq_q, wr_err_q, rd_rsp_valid_q, rd_err_q, commit_done_q;
  logic              wr_fire;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    for (int k = 0; k < STRB_W; k++) m[k*8 +: 8] = {8{strb[k]}};
    return m;
  endfunction

  assign wr_fire = bus.wr_valid && (state_q == ST_IDLE);
  assign wr_idx  = bus.wr_addr[IDX_W-1:0];
  assign rd_idx  = bus.rd_addr[IDX_W-1:0];

  // NOTE: combinational next-state uses blocking '=' and assigns a default to
  // every target first, so no latch is inferred and later lines see earlier ones.
  always_comb begin
    stg_d = stg_q;
    if (wr_fire && (bus.wr_addr < STATUS_ADDR)) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (bus.wr_strb[k]) stg_d[wr_idx][k*8 +: 8] = bus.wr_data[k*8 +: 8];
      end
    end
  end

  // A status bit raised in the same cycle as its clear stays set.
  always_comb begin
    clr = '0;
    if (wr_fire && (bus.wr_addr == STATUS_ADDR)) clr = bus.wr_data & strb_mask(bus.wr_strb);
    sticky_d = (sticky_q & ~clr) | register_status;
  end

  // Writes are stalled in COMMIT, so stg_q is already final when it is copied.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    case (state_q)
      ST_IDLE:   if (bus.commit) state_d = ST_COMMIT;
      ST_COMMIT: begin
        live_d  = stg_q;
        state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_rsp_data_d = '0;
    if (bus.rd_valid) begin
      if (bus.rd_addr < STATUS_ADDR)       rd_rsp_data_d = stg_q[rd_idx];
      else if (bus.rd_addr == STATUS_ADDR) rd_rsp_data_d = sticky_q;
    end
  end

  // NOTE: stg/live are flop arrays whose reset value the host relies on, so
  // every entry is reset; a RAM-backed array would be left unreset instead.
  always_ff @(posedge register_clk or posedge register_rst) begin
    if (register_rst) begin
      state_q        <= ST_IDLE;
      for (int i = 0; i < NUM_REGS; i++) begin
        stg_q[i]  <= RESET_VAL;
        live_q[i] <= RESET_VAL;
      end
      sticky_q       <= '0;
      irq_q          <= 1'b0;
      wr_err_q       <= 1'b0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_data_q  <= '0;
      rd_err_q       <= 1'b0;
      commit_done_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      stg_q          <= stg_d;
      live_q         <= live_d;
      sticky_q       <= sticky_d;
      irq_q          <= |sticky_q;
      wr_err_q       <= wr_fire && (bus.wr_addr > STATUS_ADDR);
      rd_rsp_valid_q <= bus.rd_valid;
      rd_rsp_data_q  <= rd_rsp_data_d;
      rd_err_q       <= bus.rd_valid && (bus.rd_addr > STATUS_ADDR);
      commit_done_q  <= (state_q == ST_COMMIT);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) register[i*DATA_W +: DATA_W] = live_q[i];
  end

  assign bus.wr_ready     = (state_q == ST_IDLE);
  assign bus.wr_err       = wr_err_q;
  assign bus.rd_rsp_valid = rd_rsp_valid_q;
  assign bus.rd_rsp_data  = rd_rsp_data_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.commit_done  = commit_done_q;
  assign irq              = irq_q;

endmodule
